// File: rtl/seq_mult_signed.sv
// seq_mult_signed: sequential shift-and-add signed multiplier.
// Operands arrive as sign-magnitude or two's complement, selected by mode.
// The core multiplies unsigned magnitudes. The product is then presented
// three ways: as a magnitude, as a two's-complement value, and as a sign
// code for the display path.
module seq_mult_signed #(
    parameter int WIDTH      = 8,  // operand width including sign, 4..32
    parameter int EARLY_EXIT = 1   // 1: stop once remaining multiplier bits are zero
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result_mag,
    output logic                 result_neg,
    output logic [2*WIDTH-1:0]   result_tc,
    output logic [3:0]           sign
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 neg_pend_q, neg_pend_d;
    logic [2*WIDTH-1:0]   res_mag_q, res_mag_d;
    logic                 res_neg_q, res_neg_d;
    logic [2*WIDTH-1:0]   res_tc_q, res_tc_d;

    logic                 load;
    logic                 run_last;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 sum_neg;

    // Unsigned magnitude of an operand in either input format. The most
    // negative two's-complement value maps to 2^(WIDTH-1), which still fits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] op,
                                                   input logic             tc);
        if (tc) begin
            return op[WIDTH-1] ? (~op + 1'b1) : op;
        end
        return {1'b0, op[WIDTH-2:0]};
    endfunction

    // Shared terms: operand acceptance, last-iteration detect, and the
    // accumulator value this iteration produces (also the final product).
    always_comb begin
        load     = start && (state_q == S_IDLE || state_q == S_DONE);
        run_last = ((EARLY_EXIT != 0) && ((mplr_q >> 1) == '0))
                   || (cnt_q == CW'(WIDTH - 1));
        acc_sum  = mplr_q[0] ? (acc_q + mcand_q) : acc_q;
        // A zero product is never reported as negative ("-0" is suppressed).
        sum_neg  = neg_pend_q && (acc_sum != '0);
    end

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block
        // and wins over every other condition, including an operation mid-RUN.
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable assigned here gets a default first; a path
        // that left one unassigned would infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (load) state_d = S_RUN;
            S_RUN:   if (run_last) state_d = S_DONE;
            S_DONE:  state_d = load ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: operand capture, one shift-and-add step per
    // RUN cycle, and result capture on the final step.
    always_comb begin
        mplr_d     = mplr_q;
        mcand_d    = mcand_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        neg_pend_d = neg_pend_q;
        res_mag_d  = res_mag_q;
        res_neg_d  = res_neg_q;
        res_tc_d   = res_tc_q;

        if (load) begin
            mplr_d     = magnitude(multiplier, mode);
            mcand_d    = {{WIDTH{1'b0}}, magnitude(multiplicand, mode)};
            acc_d      = '0;
            cnt_d      = '0;
            neg_pend_d = multiplier[WIDTH-1] ^ multiplicand[WIDTH-1];
        end else if (state_q == S_RUN) begin
            acc_d   = acc_sum;
            mplr_d  = mplr_q >> 1;
            mcand_d = mcand_q << 1;
            cnt_d   = cnt_q + 1'b1;
            if (run_last) begin
                res_mag_d = acc_sum;
                res_neg_d = sum_neg;
                res_tc_d  = sum_neg ? (~acc_sum + 1'b1) : acc_sum;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the working registers are cleared as well as the visible
            // results, so an abandoned operation leaves no residue behind.
            mplr_q     <= '0;
            mcand_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            neg_pend_q <= 1'b0;
            res_mag_q  <= '0;
            res_neg_q  <= 1'b0;
            res_tc_q   <= '0;
        end else begin
            mplr_q     <= mplr_d;
            mcand_q    <= mcand_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            neg_pend_q <= neg_pend_d;
            res_mag_q  <= res_mag_d;
            res_neg_q  <= res_neg_d;
            res_tc_q   <= res_tc_d;
        end
    end

    // Outputs: handshake decoded from state, results straight from registers.
    always_comb begin
        busy       = (state_q == S_RUN);
        done       = (state_q == S_DONE);
        result_mag = res_mag_q;
        result_neg = res_neg_q;
        result_tc  = res_tc_q;
        sign       = res_neg_q ? 4'b1010 : 4'b0000;
    end

endmodule

// File: tb/tb_seq_mult_signed.sv
// Bench for seq_mult_signed. Two instances are used: 8-bit with early
// exit and 16-bit without. Stimulus pushes hand-computed expectations into
// per-instance queues. Monitors pop and compare whenever done is seen,
// including the measured RUN length.
module tb_seq_mult_signed;

    typedef struct {
        logic [31:0] mag;
        logic        neg;
        logic [31:0] tc;
        logic [3:0]  sgn;
        int          run;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q16[$];

    // 8-bit, early exit
    logic        rst8, start8, mode8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, neg8;
    logic [15:0] mag8, tc8;
    logic [3:0]  sgn8;

    // 16-bit, fixed length
    logic        rst16, start16, mode16;
    logic [15:0] a16, b16;
    logic        busy16, done16, neg16;
    logic [31:0] mag16, tc16;
    logic [3:0]  sgn16;

    seq_mult_signed #(.WIDTH(8), .EARLY_EXIT(1)) u8 (
        .clock(clk), .reset(rst8), .start(start8), .mode(mode8),
        .multiplier(a8), .multiplicand(b8), .busy(busy8), .done(done8),
        .result_mag(mag8), .result_neg(neg8), .result_tc(tc8), .sign(sgn8)
    );

    seq_mult_signed #(.WIDTH(16), .EARLY_EXIT(0)) u16 (
        .clock(clk), .reset(rst16), .start(start16), .mode(mode16),
        .multiplier(a16), .multiplicand(b16), .busy(busy16), .done(done16),
        .result_mag(mag16), .result_neg(neg16), .result_tc(tc16), .sign(sgn16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] mag, input logic neg,
                                input logic [31:0] tc, input int run);
        exp_t e;
        e.mag = mag;
        e.neg = neg;
        e.tc  = tc;
        e.sgn = neg ? 4'b1010 : 4'b0000;
        e.run = run;
        return e;
    endfunction

    // Monitor for the 8-bit instance: counts busy cycles, checks on done.
    int run8 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst8) begin
            run8 = 0;
        end else if (done8) begin
            check("w8_busy_during_done", 64'(busy8), 64'd0);
            if (q8.size() == 0) begin
                check("w8_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q8.pop_front();
                check("w8_mag", 64'(mag8), 64'(e.mag));
                check("w8_neg", 64'(neg8), 64'(e.neg));
                check("w8_tc", 64'(tc8), 64'(e.tc));
                check("w8_sign", 64'(sgn8), 64'(e.sgn));
                check("w8_run_len", 64'(run8), 64'(e.run));
            end
            run8 = 0;
        end else if (busy8) begin
            run8++;
        end
    end

    // Monitor for the 16-bit instance.
    int run16 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst16) begin
            run16 = 0;
        end else if (done16) begin
            if (q16.size() == 0) begin
                check("w16_unexpected_done", 64'd1, 64'd0);
            end else begin
                e = q16.pop_front();
                check("w16_mag", 64'(mag16), 64'(e.mag));
                check("w16_neg", 64'(neg16), 64'(e.neg));
                check("w16_tc", 64'(tc16), 64'(e.tc));
                check("w16_sign", 64'(sgn16), 64'(e.sgn));
                check("w16_run_len", 64'(run16), 64'(e.run));
            end
            run16 = 0;
        end else if (busy16) begin
            run16++;
        end
    end

    task automatic go8(input logic m, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        mode8 = m; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    task automatic go16(input logic m, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        mode16 = m; a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
    endtask

    task automatic wait8;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done8 && n < 200);
        if (!done8) check("w8_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait16;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done16 && n < 200);
        if (!done16) check("w16_done_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_idle8(input string tag);
        check({tag, "_busy"}, 64'(busy8), 64'd0);
        check({tag, "_done"}, 64'(done8), 64'd0);
        check({tag, "_mag"}, 64'(mag8), 64'd0);
        check({tag, "_neg"}, 64'(neg8), 64'd0);
        check({tag, "_tc"}, 64'(tc8), 64'd0);
        check({tag, "_sign"}, 64'(sgn8), 64'd0);
    endtask

    // Stimulus for the 8-bit instance.
    initial begin
        rst8 = 1'b1; start8 = 1'b0; mode8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle8("w8_reset");
        rst8 = 1'b0;

        // -5 x 3, sign-magnitude
        q8.push_back(mk(32'h000F, 1'b1, 32'hFFF1, 3));
        go8(1'b0, 8'h85, 8'h03);
        wait8();

        // -128 x -128, two's complement
        q8.push_back(mk(32'h4000, 1'b0, 32'h4000, 8));
        go8(1'b1, 8'h80, 8'h80);
        wait8();

        // -0 x -7: zero product is not negative
        q8.push_back(mk(32'h0000, 1'b0, 32'h0000, 1));
        go8(1'b0, 8'h80, 8'h87);
        wait8();

        // -1 x 5, two's complement
        q8.push_back(mk(32'h0005, 1'b1, 32'hFFFB, 1));
        go8(1'b1, 8'hFF, 8'h05);
        wait8();

        // 127 x -127, two's complement
        q8.push_back(mk(32'h3F01, 1'b1, 32'hC0FF, 7));
        go8(1'b1, 8'h7F, 8'h81);
        wait8();

        // 3 x 0
        q8.push_back(mk(32'h0000, 1'b0, 32'h0000, 2));
        go8(1'b1, 8'h03, 8'h00);
        wait8();

        // 127 x 127 with a second start on RUN cycle 3 that must be ignored
        q8.push_back(mk(32'h3F01, 1'b0, 32'h3F01, 7));
        go8(1'b0, 8'h7F, 8'h7F);
        @(posedge clk);
        @(posedge clk);
        go8(1'b0, 8'h01, 8'h01);
        wait8();

        // Reset on RUN cycle 4 abandons the operation without a done
        go8(1'b0, 8'h7F, 8'h7F);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk);
        #1 rst8 = 1'b0;
        @(negedge clk);
        check_idle8("w8_midrun_reset");
        repeat (12) @(negedge clk);
        check("w8_no_done_after_reset", 64'(q8.size()), 64'd0);

        // 2 x 3 after the abandoned run
        q8.push_back(mk(32'h0006, 1'b0, 32'h0006, 2));
        go8(1'b0, 8'h02, 8'h03);
        wait8();
        repeat (3) @(negedge clk);
    end

    // Stimulus for the 16-bit instance, then the summary.
    initial begin
        rst16 = 1'b1; start16 = 1'b0; mode16 = 1'b0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("w16_reset_mag", 64'(mag16), 64'd0);
        check("w16_reset_busy", 64'(busy16), 64'd0);
        rst16 = 1'b0;

        q16.push_back(mk(32'h3FFF0001, 1'b0, 32'h3FFF0001, 16));
        go16(1'b0, 16'h7FFF, 16'h7FFF);
        wait16();

        // start held in the DONE cycle: next RUN follows immediately
        mode16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0002; start16 = 1'b1;
        q16.push_back(mk(32'h00000002, 1'b1, 32'hFFFFFFFE, 16));
        @(posedge clk);
        #1 start16 = 1'b0;
        @(negedge clk);
        check("w16_back_to_back_busy", 64'(busy16), 64'd1);
        wait16();

        // zero multiplier still runs the full length without early exit
        q16.push_back(mk(32'h0, 1'b0, 32'h0, 16));
        go16(1'b0, 16'h0000, 16'h8003);
        wait16();

        repeat (250) @(negedge clk);
        check("w8_queue_drained", 64'(q8.size()), 64'd0);
        check("w16_queue_drained", 64'(q16.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
